shift_req_arbiter: RTL and testbench

Shares one 8-bit multifunction barrel shifter among `NUM_REQ` requesters. Each requester uses a valid/ready request channel. The block picks one pending request by round-robin, computes the shift in the shared core, and returns a registered result with the requester's index on a single valid/ready response channel. Only one operation is in flight at a time. The block sits between the requester logic and the shifter core and is the only owner of the core.

---
 rtl/shifter_pkg.sv | 20 ++
 rtl/barrel_shifter_core.sv | 29 ++
 rtl/shift_req_arbiter.sv | 114 +++++++++++
 tb/tb_shift_req_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and constants for the shift request arbiter.
// Shifter widths, shift modes, and arbiter FSM states.
package shifter_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

endpackage

// File: rtl/barrel_shifter_core.sv
// Combinational 8-bit multifunction barrel shifter.
// Ports: data_i, amt_i, mode_i -> result_o (SLL/SRL/SRA/ROL).
module barrel_shifter_core
  import shifter_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  shift_mode_t       mode_i,
  output logic [DATA_W-1:0] result_o
);

  logic [2*DATA_W-1:0] rot;

  // Rotate: shift a doubled copy, the upper half wraps the
  // bits that fell off the top back into the low end.
  assign rot = {data_i, data_i} << amt_i;

  always_comb begin
    result_o = data_i;
    unique case (mode_i)
      SLL: result_o = data_i << amt_i;
      SRL: result_o = data_i >> amt_i;
      SRA: result_o = $signed(data_i) >>> amt_i;
      ROL: result_o = rot[2*DATA_W-1:DATA_W];
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_req_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NUM_REQ
// requesters; ports: req_valid/ready/data/amt/mode in, rsp_* out.
module shift_req_arbiter
  import shifter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*AMT_W-1:0]  req_amt,
  input  logic [NUM_REQ*2-1:0]      req_mode,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id
);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              found;
  logic [ID_W-1:0]   grant_idx;
  logic              can_take;
  logic              accept;
  logic [DATA_W-1:0] core_data;
  logic [AMT_W-1:0]  core_amt;
  shift_mode_t       core_mode;
  logic [DATA_W-1:0] core_res;

  // Search downward so the lowest offset from rr_ptr wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    core_data = '0;
    core_amt  = '0;
    core_mode = SLL;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        core_data = req_data[i*DATA_W +: DATA_W];
        core_amt  = req_amt[i*AMT_W +: AMT_W];
        core_mode = shift_mode_t'(req_mode[i*2 +: 2]);
      end
    end
  end

  barrel_shifter_core u_core (
    .data_i   (core_data),
    .amt_i    (core_amt),
    .mode_i   (core_mode),
    .result_o (core_res)
  );

  // A held response blocks new grants; a consumed one
  // lets the next request through in the same cycle.
  assign can_take = (state_q == IDLE) || rsp_ready;
  assign accept   = found && can_take && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
    if (accept) begin
      state_d  = RESP;
      data_d   = core_res;
      id_d     = grant_idx;
      rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ?
                 '0 : grant_idx + 1'b1;
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Self-checking bench for shift_req_arbiter (NUM_REQ=4).
// Directed literal cases followed by a randomized run vs a model.
module tb_shift_req_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [11:0] req_amt;
  logic [7:0]  req_mode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;

  shift_req_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int          m_ptr;
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_id;
  int          last_g;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_shift(int d, int a, int m);
    int r;
    case (m)
      0: r = d * (1 << a);
      1: r = d / (1 << a);
      2: r = (d >= 128) ? (((d - 256) >>> a) + 256) : (d >>> a);
      default: r = (d * (1 << a)) + (d / (1 << (8 - a)));
    endcase
    return 8'(r % 256);
  endfunction

  // Requesters ordered from the pointer upward, first valid wins.
  function automatic int pick();
    int q[$];
    for (int k = 0; k < N; k++) q.push_back((m_ptr + k) % N);
    foreach (q[j]) if (req_valid[q[j]]) return q[j];
    return -1;
  endfunction

  task automatic step();
    int g;
    bit acc;
    logic [3:0] er;
    #1;
    g   = pick();
    acc = !rst && (g >= 0) && (!m_valid || rsp_ready);
    er  = acc ? 4'(1 << g) : 4'd0;
    chk("rsp_valid", int'(rsp_valid), int'(m_valid));
    chk("rsp_data", int'(rsp_data), int'(m_data));
    chk("rsp_id", int'(rsp_id), m_id);
    chk("req_ready", int'(req_ready), int'(er));
    last_g = acc ? g : -1;
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_data = 8'h00; m_id = 0;
    end else if (acc) begin
      m_valid = 1;
      m_data  = ref_shift(int'(req_data[g*8 +: 8]),
                          int'(req_amt[g*3 +: 3]),
                          int'(req_mode[g*2 +: 2]));
      m_id    = g;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(int i, logic [7:0] d, int a, int m);
    req_data[i*8 +: 8] = d;
    req_amt[i*3 +: 3]  = 3'(a);
    req_mode[i*2 +: 2] = 2'(m);
  endtask

  logic [7:0] lit_aa [4] = '{8'h50, 8'h15, 8'hF5, 8'h55};
  logic [7:0] lit_80 [4] = '{8'h00, 8'h01, 8'hFF, 8'h40};
  bit   [3:0] hold;
  logic [1:0] held_id;

  initial begin
    rst = 1; req_valid = 0; req_data = 0; req_amt = 0;
    req_mode = 0; rsp_ready = 1;
    m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; last_g = -1;
    @(negedge clk);
    step();
    rst = 0;
    step();
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);

    for (int m = 0; m < 4; m++) begin
      req_valid = 4'b0001;
      set_req(0, 8'hAA, 3, m);
      step();
      chk("aa3_data", int'(rsp_data), int'(lit_aa[m]));
      chk("aa3_valid", int'(rsp_valid), 1);
      chk("aa3_id", int'(rsp_id), 0);
    end
    req_valid = 0;
    step();
    chk("idle_after_drain", int'(rsp_valid), 0);

    for (int m = 0; m < 4; m++) begin
      req_valid = 4'b0001;
      set_req(0, 8'hC3, 0, m);
      step();
      chk("amt0_pass", int'(rsp_data), 32'hC3);
    end
    for (int m = 0; m < 4; m++) begin
      req_valid = 4'b0001;
      set_req(0, 8'h80, 7, m);
      step();
      chk("amt7_80", int'(rsp_data), int'(lit_80[m]));
    end

    rst = 1; req_valid = 0;
    step();
    rst = 0;
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h11 * (i + 1)), i, i);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_order", int'(rsp_id), k % N);
      chk("rr_valid", int'(rsp_valid), 1);
    end

    rsp_ready = 0;
    held_id = rsp_id;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_id", int'(rsp_id), int'(held_id));
      chk("stall_ready", int'(req_ready), 0);
    end
    rsp_ready = 1;
    #1;
    chk("release_grant", int'(req_ready), 4'b0001);
    step();

    rsp_ready = 0; req_valid = 4'b0100;
    step();
    chk("pre_rst_resp", int'(rsp_valid), 1);
    rst = 1;
    step();
    chk("rst_mid_valid", int'(rsp_valid), 0);
    rst = 0; rsp_ready = 1; req_valid = 4'b0110;
    #1;
    chk("rst_fresh_grant", int'(req_ready), 4'b0010);
    step();

    req_valid = 0;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          req_valid[i] = ($urandom % 3) != 0;
          set_req(i, 8'($urandom), int'($urandom % 8),
                  int'($urandom % 4));
        end
      end
      rsp_ready = ($urandom % 10) < 7;
      rst = ($urandom % 150) == 0;
      step();
      for (int i = 0; i < N; i++)
        hold[i] = req_valid[i] && (last_g != i);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
